// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command sequencer.
// Covers operand and result widths, opcode encodings and the sequencer state enum.
package alu_pkg;

  localparam int OP_W  = 5;
  localparam int RES_W = 2 * OP_W;

  localparam logic [1:0] ALU_OP_ADD = 2'b00;
  localparam logic [1:0] ALU_OP_SUB = 2'b01;
  localparam logic [1:0] ALU_OP_MUL = 2'b10;
  localparam logic [1:0] ALU_OP_ILL = 2'b11;

  typedef enum logic [2:0] {
    SEQ_IDLE   = 3'd0,
    SEQ_LOAD_A = 3'd1,
    SEQ_LOAD_B = 3'd2,
    SEQ_EXEC   = 3'd3,
    SEQ_CAPT   = 3'd4,
    SEQ_RESP   = 3'd5
  } seq_state_e;

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Bundles the host command/response channels and the ALU strobe bus of the sequencer.
// cmd and rsp are valid/ready: a beat transfers on a rising edge where valid and ready are both high;
// the source holds its payload stable while valid is high and not yet accepted.
interface alu_cmd_sequencer_if
  import alu_pkg::*;
;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [OP_W-1:0]  cmd_a;
  logic [OP_W-1:0]  cmd_b;
  logic [1:0]       cmd_op;

  logic [OP_W-1:0]  alu_data;
  logic             alu_load_a;
  logic             alu_load_b;
  logic [1:0]       alu_op_sel;
  logic             alu_enable_out;
  logic [RES_W-1:0] alu_result;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [RES_W-1:0] rsp_data;
  logic             rsp_err;

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_op, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_op, rsp_ready, alu_result,
    output cmd_ready, rsp_valid, rsp_data, rsp_err,
    output alu_data, alu_load_a, alu_load_b, alu_op_sel, alu_enable_out
  );

  modport alu (
    input  alu_data, alu_load_a, alu_load_b, alu_op_sel, alu_enable_out,
    output alu_result
  );

endinterface

// File: rtl/alu_cmd_sequencer.sv
// Accepts one ALU command, walks the ALU through load_a -> load_b -> enable_out,
// captures the full result and returns it on the response channel.
module alu_cmd_sequencer
  import alu_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  alu_cmd_sequencer_if.slave  bus,
  output seq_state_e          state_o
);

  seq_state_e       state_q, state_d;
  logic [OP_W-1:0]  b_q, b_d;
  logic [1:0]       op_q, op_d;
  logic [OP_W-1:0]  alu_data_q, alu_data_d;
  logic             load_a_q, load_a_d;
  logic             load_b_q, load_b_d;
  logic             enable_q, enable_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [RES_W-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_err_q, rsp_err_d;

  always_comb begin
    state_d    = state_q;
    b_d        = b_q;
    op_d       = op_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;

    case (state_q)
      SEQ_IDLE: begin
        if (bus.cmd_valid) begin
          b_d = bus.cmd_b;
          if (bus.cmd_op == ALU_OP_ILL) begin
            // Illegal opcode never reaches the ALU, so op_sel keeps its previous value.
            rsp_data_d = '0;
            rsp_err_d  = 1'b1;
            state_d    = SEQ_RESP;
          end else begin
            op_d    = bus.cmd_op;
            state_d = SEQ_LOAD_A;
          end
        end
      end
      SEQ_LOAD_A: state_d = SEQ_LOAD_B;
      SEQ_LOAD_B: state_d = SEQ_EXEC;
      SEQ_EXEC:   state_d = SEQ_CAPT;
      SEQ_CAPT: begin
        rsp_data_d = bus.alu_result;
        rsp_err_d  = 1'b0;
        state_d    = SEQ_RESP;
      end
      SEQ_RESP: begin
        if (bus.rsp_ready) state_d = SEQ_IDLE;
      end
      default: state_d = SEQ_IDLE;
    endcase

    // Outputs are registered from the next state so they line up with state_q without glitches.
    load_a_d    = (state_d == SEQ_LOAD_A);
    load_b_d    = (state_d == SEQ_LOAD_B);
    enable_d    = (state_d == SEQ_EXEC);
    rsp_valid_d = (state_d == SEQ_RESP);
    if (state_d == SEQ_LOAD_A)      alu_data_d = bus.cmd_a;
    else if (state_d == SEQ_LOAD_B) alu_data_d = b_q;
    else                            alu_data_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SEQ_IDLE;
      b_q         <= '0;
      op_q        <= ALU_OP_ADD;
      alu_data_q  <= '0;
      load_a_q    <= 1'b0;
      load_b_q    <= 1'b0;
      enable_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      b_q         <= b_d;
      op_q        <= op_d;
      alu_data_q  <= alu_data_d;
      load_a_q    <= load_a_d;
      load_b_q    <= load_b_d;
      enable_q    <= enable_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign bus.cmd_ready      = (state_q == SEQ_IDLE) && !rst;
  assign bus.alu_data       = alu_data_q;
  assign bus.alu_load_a     = load_a_q;
  assign bus.alu_load_b     = load_b_q;
  assign bus.alu_enable_out = enable_q;
  assign bus.alu_op_sel     = op_q;
  assign bus.rsp_valid      = rsp_valid_q;
  assign bus.rsp_data       = rsp_data_q;
  assign bus.rsp_err        = rsp_err_q;
  assign state_o            = state_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer driving a behavioural 5-bit ALU with unreset operand registers.
module tb_alu_cmd_sequencer;
  import alu_pkg::*;

  logic clk;
  logic rst;
  seq_state_e dbg_state;

  alu_cmd_sequencer_if bus ();

  alu_cmd_sequencer u_dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus.slave),
    .state_o (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- ALU model ----------------
  logic [OP_W-1:0]  alu_a_q, alu_b_q, alu_out_q;
  logic [RES_W-1:0] alu_full;

  always_comb begin
    case (bus.alu_op_sel)
      ALU_OP_ADD: alu_full = {5'b0, 5'(alu_a_q + alu_b_q)};
      ALU_OP_SUB: alu_full = {5'b0, 5'(alu_a_q - alu_b_q)};
      ALU_OP_MUL: alu_full = 10'(alu_a_q) * 10'(alu_b_q);
      default:    alu_full = '0;
    endcase
  end

  always @(posedge clk) begin
    if (bus.alu_load_a)     alu_a_q   <= bus.alu_data;
    if (bus.alu_load_b)     alu_b_q   <= bus.alu_data;
    if (bus.alu_enable_out) alu_out_q <= alu_full[4:0];
  end

  assign bus.alu_result = {alu_full[9:5], alu_out_q};

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;
  logic [10:0] exp_q[$];
  logic [3:0]  strb;
  logic [3:0]  strb_tbl [5];

  assign strb = {bus.alu_load_a, bus.alu_load_b, bus.alu_enable_out, bus.rsp_valid};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] model(input logic [4:0] a, input logic [4:0] b, input logic [1:0] op);
    case (op)
      ALU_OP_ADD: return {1'b0, 5'b0, 5'(a + b)};
      ALU_OP_SUB: return {1'b0, 5'b0, 5'(a - b)};
      ALU_OP_MUL: return {1'b0, 10'(a) * 10'(b)};
      default:    return {1'b1, 10'b0};
    endcase
  endfunction

  // response scoreboard and strobe exclusivity monitor
  always @(negedge clk) begin
    if (!rst) begin
      chk("strobe_onehot", 32'($onehot0(strb[3:1])), 32'd1);
      if (bus.rsp_valid && bus.rsp_ready) begin
        if (exp_q.size() == 0) chk("rsp_unexpected", 32'(exp_q.size()), 32'd1);
        else chk("rsp", {21'b0, bus.rsp_err, bus.rsp_data}, {21'b0, exp_q.pop_front()});
      end
    end
  end

  // ---------------- driver tasks (entered/left at posedge+1) ----------------
  task automatic send(input logic [4:0] a, input logic [4:0] b, input logic [1:0] op);
    int n = 0;
    while (!bus.cmd_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("cmd_ready_wait", 32'(bus.cmd_ready), 32'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    bus.cmd_op    = op;
    @(posedge clk);
    exp_q.push_back(model(a, b, op));
    #1 bus.cmd_valid = 1'b0;
    if (op != ALU_OP_ILL) begin
      for (int c = 0; c < 5; c++) begin
        @(negedge clk);
        chk($sformatf("strobes_c%0d", c), 32'(strb), 32'(strb_tbl[c]));
        chk($sformatf("cmd_ready_c%0d", c), 32'(bus.cmd_ready), 32'd0);
        if (c == 0) chk("data_a", 32'(bus.alu_data), 32'(a));
        if (c == 1) chk("data_b", 32'(bus.alu_data), 32'(b));
        if (c < 4)  chk($sformatf("op_sel_c%0d", c), 32'(bus.alu_op_sel), 32'(op));
        @(posedge clk); #1;
      end
    end else begin
      @(negedge clk);
      chk("ill_no_alu", 32'(strb[3:1]), 32'd0);
      @(posedge clk); #1;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chk("drain", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_strobes"},  32'(strb),            32'd0);
    chk({tag, "_data"},     32'(bus.alu_data),    32'd0);
    chk({tag, "_op_sel"},   32'(bus.alu_op_sel),  32'd0);
    chk({tag, "_rsp_data"}, 32'(bus.rsp_data),    32'd0);
    chk({tag, "_rsp_err"},  32'(bus.rsp_err),     32'd0);
    chk({tag, "_state"},    32'(dbg_state),       32'(SEQ_IDLE));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    strb_tbl[0] = 4'b1000;
    strb_tbl[1] = 4'b0100;
    strb_tbl[2] = 4'b0010;
    strb_tbl[3] = 4'b0000;
    strb_tbl[4] = 4'b0001;
    rst = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_a = '0;
    bus.cmd_b = '0;
    bus.cmd_op = '0;
    bus.rsp_ready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    chk_reset_outputs("rst");
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("idle_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    @(posedge clk); #1;

    send(5'd7, 5'd9, ALU_OP_ADD);   drain();
    send(5'd3, 5'd5, ALU_OP_SUB);   drain();
    send(5'd31, 5'd31, ALU_OP_MUL); drain();

    // illegal opcode, response held so its timing is visible
    bus.rsp_ready = 1'b0;
    send(5'd18, 5'd5, ALU_OP_ILL);
    @(negedge clk);
    chk("ill_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("ill_rsp_data",  32'(bus.rsp_data),  32'd0);
    chk("ill_rsp_err",   32'(bus.rsp_err),   32'd1);
    @(posedge clk); #1 bus.rsp_ready = 1'b1;
    drain();

    // backpressure with a stray command during the stall
    bus.rsp_ready = 1'b0;
    send(5'd4, 5'd6, ALU_OP_MUL);
    bus.cmd_valid = 1'b1;
    bus.cmd_a = 5'd1;
    bus.cmd_b = 5'd1;
    bus.cmd_op = ALU_OP_ADD;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("stall_rsp_data",  32'(bus.rsp_data),  32'h018);
      chk("stall_cmd_ready", 32'(bus.cmd_ready), 32'd0);
      @(posedge clk); #1;
    end
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("release_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("release_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stray_not_taken", 32'(strb), 32'd0);
    end
    @(posedge clk); #1;
    drain();

    // response handshake and new command in the same cycle
    bus.rsp_ready = 1'b0;
    send(5'd2, 5'd3, ALU_OP_ADD);
    bus.cmd_valid = 1'b1;
    bus.cmd_a = 5'd4;
    bus.cmd_b = 5'd4;
    bus.cmd_op = ALU_OP_ADD;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("same_cyc_ready", 32'(bus.cmd_ready), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("same_cyc_idle_ready", 32'(bus.cmd_ready), 32'd1);
    chk("same_cyc_no_load", 32'(bus.alu_load_a), 32'd0);
    @(posedge clk);
    exp_q.push_back(model(5'd4, 5'd4, ALU_OP_ADD));
    #1 bus.cmd_valid = 1'b0;
    @(negedge clk);
    chk("same_cyc_load_a", 32'(bus.alu_load_a), 32'd1);
    chk("same_cyc_data_a", 32'(bus.alu_data), 32'd4);
    @(posedge clk); #1;
    drain();

    // reset during LOAD_B drops the command
    bus.cmd_valid = 1'b1;
    bus.cmd_a = 5'd5;
    bus.cmd_b = 5'd6;
    bus.cmd_op = ALU_OP_ADD;
    @(posedge clk); #1 bus.cmd_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("midrst_in_load_b", 32'(bus.alu_load_b), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("midrst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    chk_reset_outputs("midrst");
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_no_rsp", 32'(bus.rsp_valid), 32'd0);
    chk("midrst_ready", 32'(bus.cmd_ready), 32'd1);
    @(posedge clk); #1;
    send(5'd1, 5'd1, ALU_OP_ADD);
    drain();

    // random commands with occasional response stall
    for (int i = 0; i < 16; i++) begin
      logic [4:0] ra, rb;
      logic [1:0] rop;
      ra  = 5'($urandom_range(0, 31));
      rb  = 5'($urandom_range(0, 31));
      rop = 2'($urandom_range(0, 3));
      bus.rsp_ready = 1'($urandom_range(0, 1));
      send(ra, rb, rop);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1 bus.rsp_ready = 1'b1;
      drain();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
